bus_arbiter: RTL

- Two-master bus arbiter and master-side multiplexer for the shared 8-bit address bus.
- Decides which master (M0 or M1) owns the bus, then routes that master's address, write-data and write-enable onto the shared bus.
- Its M_address output is the sel_address input of the slave address decoder: 0x1X selects slave 0, 0x2X selects slave 1, anything else selects neither.
- Sits between the masters (e.g. testbench or CPU model) and the address decoder / slave mux.

---
 rtl/bus_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//   Two-master arbiter plus master-side multiplexer for the shared address bus.
//   A single state register records which master owns the bus. The owner's
//   address, write data and write enable are routed onto the shared bus while
//   it is requesting. When the owner is idle the bus is driven to all-zero, so
//   the downstream address decoder selects no slave.
//
//   Arbitration: the owner keeps the bus for as long as it requests. Ownership
//   passes to the other master one edge after the owner drops its request and
//   the other master is requesting. With nobody requesting, the bus parks on
//   (or returns to) M0.
//
//   Optional feature (macro BUS_ARB_TIMEOUT_EN): limits a continuous grant to
//   TIMEOUT_CYCLES cycles while the other master is waiting. Without the
//   macro, no counter exists and the owner may hold the bus indefinitely.
//
// Parameters
//   ADDR_WIDTH      shared address width (fixed at 8 to match the decoder)
//   DATA_WIDTH      write-data width
//   TIMEOUT_CYCLES  maximum continuous grant length, 2..255 (timeout build)
//
// Ports
//   clk         in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   M0_req      in   master 0 bus request
//   M0_wr       in   master 0 write enable
//   M0_address  in   master 0 address
//   M0_dout     in   master 0 write data
//   M1_req      in   master 1 bus request
//   M1_wr       in   master 1 write enable
//   M1_address  in   master 1 address
//   M1_dout     in   master 1 write data
//   M0_grant    out  master 0 owns the bus (decoded from the state register)
//   M1_grant    out  master 1 owns the bus (decoded from the state register)
//   M_req       out  owning master is requesting
//   M_wr        out  shared write enable
//   M_address   out  shared address (decoder sel_address)
//   M_dout      out  shared write data
// -----------------------------------------------------------------------------
module bus_arbiter #(
   parameter int ADDR_WIDTH     = 8,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  M0_req,
   input  logic                  M0_wr,
   input  logic [ADDR_WIDTH-1:0] M0_address,
   input  logic [DATA_WIDTH-1:0] M0_dout,
   input  logic                  M1_req,
   input  logic                  M1_wr,
   input  logic [ADDR_WIDTH-1:0] M1_address,
   input  logic [DATA_WIDTH-1:0] M1_dout,
   output logic                  M0_grant,
   output logic                  M1_grant,
   output logic                  M_req,
   output logic                  M_wr,
   output logic [ADDR_WIDTH-1:0] M_address,
   output logic [DATA_WIDTH-1:0] M_dout
);

   // Elaboration-time legality checks on the configuration.
   if (ADDR_WIDTH != 8) begin : g_bad_addr_width
      $error("bus_arbiter: ADDR_WIDTH must be 8");
   end
   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("bus_arbiter: TIMEOUT_CYCLES must be in 2..255");
   end

   typedef enum logic {
      M0_GRANT = 1'b0,
      M1_GRANT = 1'b1
   } state_t;

   state_t r_state;
   state_t w_state_nxt;
   logic   w_own_req;

   // Request of whichever master currently owns the bus.
   assign w_own_req = (r_state == M0_GRANT) ? M0_req : M1_req;

`ifdef BUS_ARB_TIMEOUT_EN
   localparam logic [7:0] LP_CNT_MAX = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] r_cnt;
   logic [7:0] w_cnt_nxt;
   logic       w_expired;

   assign w_expired = (r_cnt == LP_CNT_MAX);
`endif

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= M0_GRANT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         M0_GRANT: begin
            if (!M0_req && M1_req) begin
               w_state_nxt = M1_GRANT;
`ifdef BUS_ARB_TIMEOUT_EN
            end else if (M0_req && M1_req && w_expired) begin
               // M0 has used up its slice while M1 waits: force a handover.
               w_state_nxt = M1_GRANT;
`endif
            end
         end
         M1_GRANT: begin
            // An idle M1 always hands back to M0, which is the park owner.
            if (!M1_req) begin
               w_state_nxt = M0_GRANT;
`ifdef BUS_ARB_TIMEOUT_EN
            end else if (M0_req && w_expired) begin
               w_state_nxt = M0_GRANT;
`endif
            end
         end
         default: w_state_nxt = M0_GRANT;
      endcase
   end

`ifdef BUS_ARB_TIMEOUT_EN
   // Grant-length counter: counts consecutive busy cycles of the current
   // owner, restarts on any ownership change or idle cycle, and saturates at
   // the limit so a lone requester keeps the bus while remaining "expired",
   // ready to yield on the first cycle the other master asks.
   always_comb begin
      w_cnt_nxt = r_cnt;
      if ((w_state_nxt != r_state) || !w_own_req) begin
         w_cnt_nxt = '0;
      end else if (!w_expired) begin
         w_cnt_nxt = r_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_nxt;
      end
   end
`endif

   assign M0_grant = (r_state == M0_GRANT);
   assign M1_grant = (r_state == M1_GRANT);

   // Shared-bus multiplexer: the non-owner never reaches the bus, and an idle
   // owner drives zeros so the decoder sees an unmapped address.
   always_comb begin
      M_req     = w_own_req;
      M_wr      = 1'b0;
      M_address = '0;
      M_dout    = '0;
      if (w_own_req) begin
         if (r_state == M0_GRANT) begin
            M_wr      = M0_wr;
            M_address = M0_address;
            M_dout    = M0_dout;
         end else begin
            M_wr      = M1_wr;
            M_address = M1_address;
            M_dout    = M1_dout;
         end
      end
   end

endmodule
